// File: rtl/tc_timer_if.sv
// CPU data-bus view of the timer peripheral.
// Master is the CPU side, slave is the timer.
interface tc_timer_if;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output addr, we, byteen, wdata,
      input  rdata, irq
   );

   modport slave (
      input  addr, we, byteen, wdata,
      output rdata, irq
   );
endinterface

// File: rtl/tc_timer_dev.sv
// Memory-mapped down-counting timer with CTRL, PRESET, COUNT.
// One-shot or auto-reload; level interrupt gated by CTRL.IM.
module tc_timer_dev #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input logic       clk,
   input logic       reset,
   tc_timer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic [31:0] count_nx;
   logic        irq_flag;
   logic        flag_set;
   logic        flag_clr;
   logic        en_clr;
   logic        hit;
   logic [1:0]  sel;
   logic        wr_ctrl;
   logic        wr_preset;
   logic [31:0] preset_merged;
   logic [31:0] rdata;

   assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign sel       = bus.addr[3:2];
   assign wr_ctrl   = bus.we & hit & (sel == 2'd0);
   assign wr_preset = bus.we & hit & (sel == 2'd1);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         preset_merged[8*i +: 8] = bus.byteen[i] ?
            bus.wdata[8*i +: 8] : preset[8*i +: 8];
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      flag_set = 1'b0;
      flag_clr = 1'b0;
      en_clr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (ctrl[0]) state_nx = S_LOAD;
         end
         S_LOAD: begin
            count_nx = preset;
            state_nx = S_CNT;
         end
         S_CNT: begin
            if (!ctrl[0]) begin
               state_nx = S_IDLE;
            end else if (count > 32'd1) begin
               count_nx = count - 32'd1;
            end else begin
               count_nx = 32'd0;
               flag_set = 1'b1;
               state_nx = S_INT;
            end
         end
         S_INT: begin
            state_nx = S_IDLE;
            // MODE 1x falls back to one-shot
            if (ctrl[2:1] == 2'b01) flag_clr = 1'b1;
            else                    en_clr   = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         // a bus write to CTRL overrides the one-shot EN clear
         if (wr_ctrl) begin
            if (bus.byteen[0]) ctrl <= bus.wdata[3:0];
         end else if (en_clr) begin
            ctrl[0] <= 1'b0;
         end
         if (flag_set)                irq_flag <= 1'b1;
         else if (flag_clr | wr_ctrl) irq_flag <= 1'b0;
         if (wr_preset) preset <= preset_merged;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (hit) begin
         unique case (sel)
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
         endcase
      end
   end

   assign bus.rdata = rdata;
   assign bus.irq   = irq_flag & ctrl[3];

endmodule

// File: tb/tb_tc_timer_dev.sv
// Bench for tc_timer_dev: directed scenarios plus random
// runs checked against a closed-form timeline model.
module tb_tc_timer_dev;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   localparam logic [31:0] A_CTRL = 32'h0000_7F00;
   localparam logic [31:0] A_PRE  = 32'h0000_7F04;
   localparam logic [31:0] A_CNT  = 32'h0000_7F08;
   localparam logic [31:0] A_RSV  = 32'h0000_7F0C;

   tc_timer_if bus ();

   tc_timer_dev #(.BASE_ADDR(32'h0000_7F00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] d);
      @(negedge clk);
      bus.addr = a; bus.we = 1'b1; bus.byteen = be; bus.wdata = d;
      @(posedge clk);
      #1;
      bus.we = 1'b0; bus.byteen = 4'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   // Timeline k = edges since the EN-setting write; one period is
   // LOAD(k=1), COUNT=P..1 (k=2..pe+1), flag/0 (k=pe+2), idle (k=pe+3).
   function automatic void ref_at(input int p, input bit auto_m, input int k,
                                  output logic [31:0] c, output bit f,
                                  output bit en);
      int pe, per, ke;
      pe  = (p < 1) ? 1 : p;
      per = pe + 3;
      ke  = auto_m ? ((k - 1) % per) + 1 : k;
      if (!auto_m && k >= per) begin
         c = 32'd0; f = 1'b1; en = 1'b0;
      end else begin
         en = 1'b1;
         f  = (ke == pe + 2);
         if (ke < 2 || ke >= pe + 2) c = 32'd0;
         else                        c = 32'(p - (ke - 2));
      end
   endfunction

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      rd(A_CTRL, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", v); end
      rd(A_PRE, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL reset_preset got=%h exp=0", v); end
      rd(A_CNT, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", v); end
      checks++;
      if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
   endtask

   task automatic test_byteen();
      logic [31:0] v;
      wr(A_PRE, 4'hF, 32'hFFFF_FFFF);
      wr(A_PRE, 4'b0011, 32'hABCD_1234);
      rd(A_PRE, v); checks++;
      if (v !== 32'hFFFF_1234) begin failures++; $display("FAIL be_low got=%h exp=ffff1234", v); end
      wr(A_PRE, 4'b1100, 32'h5566_0000);
      rd(A_PRE, v); checks++;
      if (v !== 32'h5566_1234) begin failures++; $display("FAIL be_high got=%h exp=55661234", v); end
      wr(A_CNT, 4'hF, 32'hDEAD_BEEF);
      rd(A_CNT, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL count_ro got=%h exp=0", v); end
      wr(A_RSV, 4'hF, 32'h1234_5678);
      rd(A_RSV, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rsv_read got=%h exp=0", v); end
      wr(32'h0001_7F04, 4'hF, 32'h0BAD_0BAD);
      wr(32'h0000_7F14, 4'hF, 32'h0BAD_0BAD);
      rd(A_PRE, v); checks++;
      if (v !== 32'h5566_1234) begin failures++; $display("FAIL outside_wr got=%h exp=55661234", v); end
      rd(32'h0000_7F14, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL outside_rd got=%h exp=0", v); end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      logic [31:0] exp;
      wr(A_PRE, 4'hF, 32'd5);
      wr(A_CTRL, 4'hF, 32'h9);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k >= 2) begin
            exp = (k - 2 >= 5) ? 32'd0 : 32'(5 - (k - 2));
            rd(A_CNT, v); checks++;
            if (v !== exp) begin failures++; $display("FAIL os_count k=%0d got=%0d exp=%0d", k, v, exp); end
         end
         checks++;
         if (bus.irq !== (k >= 7)) begin failures++; $display("FAIL os_irq k=%0d got=%b exp=%b", k, bus.irq, k >= 7); end
      end
      rd(A_CTRL, v); checks++;
      if (v !== 32'h8) begin failures++; $display("FAIL os_ctrl got=%h exp=8", v); end
      wr(A_CTRL, 4'hF, 32'h8);
      checks++;
      if (bus.irq !== 1'b0) begin failures++; $display("FAIL os_irq_clr got=%b exp=0", bus.irq); end
   endtask

   task automatic test_im0();
      logic [31:0] v;
      wr(A_PRE, 4'hF, 32'd3);
      wr(A_CTRL, 4'hF, 32'h1);
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (bus.irq !== 1'b0) begin failures++; $display("FAIL im0_irq k=%0d got=%b exp=0", k, bus.irq); end
      end
      rd(A_CTRL, v); checks++;
      if (v !== 32'h0) begin failures++; $display("FAIL im0_ctrl got=%h exp=0", v); end
      wr(A_CTRL, 4'hF, 32'h8);
      checks++;
      if (bus.irq !== 1'b0) begin failures++; $display("FAIL im0_flag_clr got=%b exp=0", bus.irq); end
   endtask

   task automatic test_auto_reload();
      logic [31:0] v;
      wr(A_PRE, 4'hF, 32'd2);
      wr(A_CTRL, 4'hF, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         step();
         checks++;
         if (bus.irq !== (k % 5 == 4)) begin failures++; $display("FAIL ar_irq k=%0d got=%b exp=%b", k, bus.irq, k % 5 == 4); end
         if (k % 5 == 2) begin
            rd(A_CNT, v); checks++;
            if (v !== 32'd2) begin failures++; $display("FAIL ar_reload k=%0d got=%0d exp=2", k, v); end
         end
      end
      wr(A_CTRL, 4'hF, 32'h0);
      repeat (4) step();
   endtask

   task automatic test_midstop();
      logic [31:0] v;
      wr(A_PRE, 4'hF, 32'd6);
      wr(A_CTRL, 4'hF, 32'h9);
      repeat (3) step();
      wr(A_PRE, 4'hF, 32'd2);
      rd(A_CNT, v); checks++;
      if (v !== 32'd4) begin failures++; $display("FAIL pre_in_cnt got=%0d exp=4", v); end
      wr(A_CTRL, 4'hF, 32'h8);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         rd(A_CNT, v); checks++;
         if (v !== 32'd3) begin failures++; $display("FAIL frozen k=%0d got=%0d exp=3", k, v); end
      end
      wr(A_CTRL, 4'hF, 32'h9);
      repeat (2) step();
      rd(A_CNT, v); checks++;
      if (v !== 32'd2) begin failures++; $display("FAIL reenable got=%0d exp=2", v); end
      wr(A_CTRL, 4'hF, 32'h0);
      repeat (4) step();
   endtask

   task automatic test_random();
      logic [31:0] v, c;
      bit f, en, auto_m;
      int p, mode, im, pe, n;
      for (int it = 0; it < 10; it++) begin
         p      = $urandom_range(0, 6);
         mode   = $urandom_range(0, 3);
         im     = $urandom_range(0, 1);
         auto_m = (mode == 1);
         pe     = (p < 1) ? 1 : p;
         n      = auto_m ? 3 * (pe + 3) : pe + 5;
         wr(A_PRE, 4'hF, 32'(p));
         wr(A_CTRL, 4'h1, {28'd0, 1'(im), 2'(mode), 1'b1});
         for (int k = 1; k <= n; k++) begin
            step();
            ref_at(p, auto_m, k, c, f, en);
            if (k > 1) begin
               rd(A_CNT, v); checks++;
               if (v !== c) begin failures++; $display("FAIL rnd_count p=%0d m=%0d k=%0d got=%0d exp=%0d", p, mode, k, v, c); end
            end
            rd(A_CTRL, v); checks++;
            if (v !== {28'd0, 1'(im), 2'(mode), en}) begin failures++; $display("FAIL rnd_ctrl p=%0d m=%0d k=%0d got=%h exp=%h", p, mode, k, v, {28'd0, 1'(im), 2'(mode), en}); end
            checks++;
            if (bus.irq !== (f & (im == 1))) begin failures++; $display("FAIL rnd_irq p=%0d m=%0d k=%0d got=%b exp=%b", p, mode, k, bus.irq, f & (im == 1)); end
         end
         wr(A_CTRL, 4'hF, 32'h0);
         repeat (4) step();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wr(A_PRE, 4'hF, 32'd5);
      wr(A_CTRL, 4'hF, 32'h9);
      repeat (4) step();
      rd(A_CNT, v); checks++;
      if (v !== 32'd3) begin failures++; $display("FAIL rm_pre got=%0d exp=3", v); end
      @(negedge clk);
      reset = 1'b1;
      bus.addr = A_PRE; bus.we = 1'b1; bus.byteen = 4'hF; bus.wdata = 32'h77;
      step();
      reset = 1'b0; bus.we = 1'b0; bus.byteen = 4'd0;
      rd(A_CNT, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", v); end
      rd(A_PRE, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rm_preset got=%h exp=0", v); end
      rd(A_CTRL, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rm_ctrl got=%h exp=0", v); end
      checks++;
      if (bus.irq !== 1'b0) begin failures++; $display("FAIL rm_irq got=%b exp=0", bus.irq); end
      repeat (3) step();
      rd(A_CNT, v); checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rm_idle got=%0d exp=0", v); end
   endtask

   initial begin
      reset      = 1'b1;
      bus.addr   = 32'd0;
      bus.we     = 1'b0;
      bus.byteen = 4'd0;
      bus.wdata  = 32'd0;
      test_reset();
      test_byteen();
      test_oneshot();
      test_im0();
      test_auto_reload();
      test_midstop();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
